sop_share_sequencer: RTL and testbench



---
 rtl/sop_share_pkg.sv | 33 +++
 rtl/sop_product_eval.sv | 17 +
 rtl/sop_share_sequencer.sv | 144 ++++++++++++++
 tb/tb_sop_share_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sop_share_pkg.sv
// Shared types for the time-multiplexed SOP evaluator: FSM states, config word layout, unpack helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Config word layout (LSB first): positive-literal mask, negative-literal mask, output activation.
package sop_share_pkg;

  localparam int N_IN_DEF  = 4;
  localparam int N_OUT_DEF = 3;
  localparam int CW_DEF    = 2*N_IN_DEF + N_OUT_DEF;

  localparam int POS_LSB = 0;
  localparam int NEG_LSB = N_IN_DEF;
  localparam int ACT_LSB = 2*N_IN_DEF;

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  typedef logic [CW_DEF-1:0] cfg_word_t;

  typedef struct packed {
    logic [N_OUT_DEF-1:0] act;
    logic [N_IN_DEF-1:0]  neg;
    logic [N_IN_DEF-1:0]  pos;
  } cfg_fields_t;

  function automatic cfg_fields_t cfg_unpack(input cfg_word_t w);
    cfg_fields_t f;
    f.pos = w[POS_LSB +: N_IN_DEF];
    f.neg = w[NEG_LSB +: N_IN_DEF];
    f.act = w[ACT_LSB +: N_OUT_DEF];
    return f;
  endfunction

endpackage

// File: rtl/sop_product_eval.sv
// Single shared product-term evaluator: AND of the selected true/complemented literals.
// Latency: purely combinational.
// Backpressure: none.
// Ports: pos/neg literal masks, in_data operand, prod result (empty product = 1, pos&neg on one bit = 0).
module sop_product_eval #(
  parameter int N_IN = 4
) (
  input  logic [N_IN-1:0] pos,
  input  logic [N_IN-1:0] neg,
  input  logic [N_IN-1:0] in_data,
  output logic            prod
);

  // A literal bit that is not selected contributes a 1 to the AND.
  assign prod = &((~pos | in_data) & (~neg | ~in_data));

endmodule

// File: rtl/sop_share_sequencer.sv
// Run-time-loadable SOP evaluator stepping one product term per cycle through one shared evaluator.
// Latency: in handshake at cycle t -> out_valid at t+PIT+1; one result per PIT+2 cycles with out_ready high.
// Backpressure: result held in DONE until out_ready; cfg/in accepted only in IDLE, cfg wins over in.
// Ports: clk/rst_n; cfg_valid/cfg_ready/cfg_addr/cfg_data table write; in_valid/in_ready/in_data operand;
//   out_valid/out_ready/out_data result; busy (EVAL); cfg_err sticky literal-limit error.
// Optional: SOP_LPP_CHECK_EN rejects writes with more than LPP literals and flags cfg_err.
module sop_share_sequencer
  import sop_share_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int N_OUT = N_OUT_DEF,
  parameter int PIT   = 10,
  parameter int LPP   = 5,
  parameter int AW    = (PIT > 1) ? $clog2(PIT) : 1,
  parameter int CW    = 2*N_IN + N_OUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [CW-1:0]    cfg_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] out_data,
  output logic             busy,
  output logic             cfg_err
);

  // Field widths of the table follow the package layout; N_IN/N_OUT track the package defaults.
  state_t            state, state_nxt;
  logic [N_IN-1:0]   tbl_pos [PIT];
  logic [N_IN-1:0]   tbl_neg [PIT];
  logic [N_OUT-1:0]  tbl_act [PIT];
  logic [AW-1:0]     cnt;
  logic [N_IN-1:0]   opnd;
  logic [N_OUT-1:0]  acc;
  logic              prod;
  cfg_fields_t       cfg_f;
  logic              cfg_hs, in_hs, addr_ok, store_ok, last_term;

  assign cfg_f     = cfg_unpack(cfg_data);
  assign cfg_hs    = cfg_valid & cfg_ready;
  assign in_hs     = in_valid & in_ready;
  assign addr_ok   = int'(cfg_addr) < PIT;
  assign last_term = (cnt == AW'(PIT-1));

`ifdef SOP_LPP_CHECK_EN
  function automatic int lit_count(input logic [N_IN-1:0] m);
    int n;
    n = 0;
    for (int i = 0; i < N_IN; i++) n = n + int'(m[i]);
    return n;
  endfunction

  logic lpp_bad;
  logic err_q;

  assign lpp_bad  = lit_count(cfg_f.pos | cfg_f.neg) > LPP;
  // An over-limit write is still acknowledged, it just never reaches the table.
  assign store_ok = cfg_hs & addr_ok & ~lpp_bad;
  assign cfg_err  = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                err_q <= 1'b0;
    else if (cfg_hs & lpp_bad) err_q <= 1'b1;
  end
`else
  assign store_ok = cfg_hs & addr_ok;
  // LPP only matters to the literal check; this constant keeps the flag low in this build.
  assign cfg_err  = 1'b0 & (LPP != 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        // A pending config write blocks the operand so the table is settled before evaluation.
        in_ready  = ~cfg_valid;
        if (in_valid && !cfg_valid) state_nxt = EVAL;
      end
      EVAL: begin
        busy = 1'b1;
        if (last_term) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out_data = (state == DONE) ? acc : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      opnd <= '0;
      acc  <= '0;
      for (int p = 0; p < PIT; p++) begin
        tbl_pos[p] <= '0;
        tbl_neg[p] <= '0;
        tbl_act[p] <= '0;
      end
    end else begin
      if (store_ok) begin
        tbl_pos[cfg_addr] <= cfg_f.pos;
        tbl_neg[cfg_addr] <= cfg_f.neg;
        tbl_act[cfg_addr] <= cfg_f.act;
      end
      if (in_hs) begin
        opnd <= in_data;
        acc  <= '0;
        cnt  <= '0;
      end else if (state == EVAL) begin
        acc <= acc | ({N_OUT{prod}} & tbl_act[cnt]);
        // Hold at the last index; the IDLE reload is the only wrap.
        if (!last_term) cnt <= cnt + 1'b1;
      end
    end
  end

  sop_product_eval #(.N_IN(N_IN)) u_prod (
    .pos     (tbl_pos[cnt]),
    .neg     (tbl_neg[cnt]),
    .in_data (opnd),
    .prod    (prod)
  );

endmodule

// File: tb/tb_sop_share_sequencer.sv
module tb_sop_share_sequencer;

  localparam int PIT   = 10;
  localparam int N_IN  = 4;
  localparam int N_OUT = 3;
  localparam int AW    = 4;
  localparam int CW    = 2*N_IN + N_OUT;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [AW-1:0]    cfg_addr;
  logic [CW-1:0]    cfg_data;
  logic             in_valid;
  logic             in_ready;
  logic [N_IN-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [N_OUT-1:0] out_data;
  logic             busy;
  logic             cfg_err;

  int checks = 0;
  int failures = 0;

  logic [N_IN-1:0]  m_pos [PIT];
  logic [N_IN-1:0]  m_neg [PIT];
  logic [N_OUT-1:0] m_act [PIT];

  always #5 clk = ~clk;

  sop_share_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .PIT(PIT), .LPP(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .cfg_err(cfg_err)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [N_OUT-1:0] model(input logic [N_IN-1:0] v);
    logic [N_OUT-1:0] r;
    logic pr;
    r = '0;
    for (int p = 0; p < PIT; p++) begin
      pr = 1'b1;
      for (int i = 0; i < N_IN; i++) begin
        if (m_pos[p][i] && !v[i]) pr = 1'b0;
        if (m_neg[p][i] &&  v[i]) pr = 1'b0;
      end
      if (pr) r = r | m_act[p];
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int p = 0; p < PIT; p++) begin
      m_pos[p] = '0; m_neg[p] = '0; m_act[p] = '0;
    end
  endtask

  task automatic model_set(input int a, input logic [3:0] pos, input logic [3:0] neg, input logic [2:0] act);
    m_pos[a] = pos; m_neg[a] = neg; m_act[a] = act;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    model_clear();
    @(posedge clk); #1;
  endtask

  task automatic cfg_write(input logic [AW-1:0] a, input logic [3:0] pos, input logic [3:0] neg,
                           input logic [2:0] act);
    cfg_valid = 1'b1;
    cfg_addr  = a;
    cfg_data  = {act, neg, pos};
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic start_eval(input logic [3:0] v, output logic b_busy, output logic b_crdy,
                            output logic b_irdy);
    in_valid = 1'b1;
    in_data  = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = ~v;
    b_busy = busy; b_crdy = cfg_ready; b_irdy = in_ready;
  endtask

  task automatic wait_out(output int lat);
    lat = -1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      if (out_valid) lat = k;
      else if (k < 40) begin @(posedge clk); #1; end
    end
  endtask

  task automatic finish_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_eval(input logic [3:0] v, output logic [2:0] res, output int lat);
    logic b1, b2, b3;
    start_eval(v, b1, b2, b3);
    wait_out(lat);
    res = out_data;
    if (lat > 0) finish_out();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL rst_cfg_ready: got %b want 1", cfg_ready); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 3'b000) begin failures++; $display("FAIL rst_out_data: got %b want 000", out_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL rst_cfg_err: got %b want 0", cfg_err); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_lpp_check();
    logic [2:0] res;
    int lat;
    cfg_write(4'd1, 4'b0111, 4'b0000, 3'b111);
`ifdef SOP_LPP_CHECK_EN
    checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL lpp_err_set: got %b want 1", cfg_err); end
    run_eval(4'b0111, res, lat);
    checks++; if (res !== 3'b000) begin failures++; $display("FAIL lpp_reject: got %b want 000", res); end
    cfg_write(4'd1, 4'b0011, 4'b0000, 3'b111);
    run_eval(4'b0011, res, lat);
    checks++; if (res !== 3'b111) begin failures++; $display("FAIL lpp_accept: got %b want 111", res); end
    checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL lpp_err_sticky: got %b want 1", cfg_err); end
`else
    run_eval(4'b0111, res, lat);
    checks++; if (res !== 3'b111) begin failures++; $display("FAIL nolpp_store: got %b want 111", res); end
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL nolpp_err: got %b want 0", cfg_err); end
`endif
    do_reset();
  endtask

  task automatic test_empty_table();
    logic b_busy, b_crdy, b_irdy;
    int lat;
    start_eval(4'b1111, b_busy, b_crdy, b_irdy);
    checks++; if (b_busy !== 1'b1) begin failures++; $display("FAIL eval_busy: got %b want 1", b_busy); end
    checks++; if (b_crdy !== 1'b0) begin failures++; $display("FAIL eval_cfg_ready: got %b want 0", b_crdy); end
    checks++; if (b_irdy !== 1'b0) begin failures++; $display("FAIL eval_in_ready: got %b want 0", b_irdy); end
    wait_out(lat);
    checks++; if (lat !== PIT+1) begin failures++; $display("FAIL empty_latency: got %0d want %0d", lat, PIT+1); end
    checks++; if (out_data !== 3'b000) begin failures++; $display("FAIL empty_data: got %b want 000", out_data); end
    if (lat > 0) finish_out();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL empty_release: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL empty_idle: got %b want 1", in_ready); end
  endtask

  task automatic test_single_product();
    logic [2:0] res;
    int lat;
    cfg_write(4'd2, 4'b1000, 4'b0110, 3'b011);
    run_eval(4'b1000, res, lat);
    checks++; if (res !== 3'b011) begin failures++; $display("FAIL p2_hit: got %b want 011", res); end
    checks++; if (lat !== PIT+1) begin failures++; $display("FAIL p2_latency: got %0d want %0d", lat, PIT+1); end
    run_eval(4'b1010, res, lat);
    checks++; if (res !== 3'b000) begin failures++; $display("FAIL p2_miss: got %b want 000", res); end
    // Out-of-range address: an empty product there would light every output if stored.
    cfg_write(4'd12, 4'b0000, 4'b0000, 3'b111);
    run_eval(4'b1010, res, lat);
    checks++; if (res !== 3'b000) begin failures++; $display("FAIL oob_drop: got %b want 000", res); end
  endtask

  task automatic test_full_table();
    logic [2:0] res;
    int lat;
    logic [3:0] v;
    logic [3:0] tp [PIT];
    logic [3:0] tn [PIT];
    logic [2:0] ta [PIT];
    do_reset();
    for (int p = 0; p < PIT; p++) begin tp[p] = '0; tn[p] = '0; ta[p] = '0; end
    tp[0] = 4'b1110; ta[0] = 3'b100;                    // in1&in2&in3 -> out2
    tp[9] = 4'b0010; ta[9] = 3'b010;                    // in1 -> out1
    tn[7] = 4'b0110; ta[7] = 3'b001;                    // ~in1&~in2 -> out0
    tp[2] = 4'b1000; tn[2] = 4'b0110; ta[2] = 3'b011;
    ta[4] = 3'b000;                                     // empty product, no outputs
    tp[5] = 4'b0001; tn[5] = 4'b0001; ta[5] = 3'b111;  // contradictory literals -> 0
    for (int p = 0; p < PIT; p++) begin
      cfg_write(AW'(p), tp[p], tn[p], ta[p]);
      model_set(p, tp[p], tn[p], ta[p]);
    end
    run_eval(4'b1110, res, lat);
    checks++; if (res !== 3'b110) begin failures++; $display("FAIL full_1110: got %b want 110", res); end
    run_eval(4'b0000, res, lat);
    checks++; if (res !== 3'b001) begin failures++; $display("FAIL full_0000: got %b want 001", res); end
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      run_eval(v, res, lat);
      checks++; if (res !== model(v) || lat !== PIT+1) begin
        failures++;
        $display("FAIL sweep_%0d: got %b lat %0d want %b lat %0d", i, res, lat, model(v), PIT+1);
      end
    end
  endtask

  task automatic test_collision();
    logic [2:0] res;
    int lat;
    logic b1, b2, b3;
    cfg_valid = 1'b1; cfg_addr = 4'd3; cfg_data = {3'b111, 4'b0000, 4'b0001};
    in_valid  = 1'b1; in_data  = 4'b0001;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL coll_in_ready: got %b want 0", in_ready); end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL coll_cfg_ready: got %b want 1", cfg_ready); end
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    model_set(3, 4'b0001, 4'b0000, 3'b111);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL coll_in_ready_next: got %b want 1", in_ready); end
    start_eval(4'b0001, b1, b2, b3);
    wait_out(lat);
    res = out_data;
    if (lat > 0) finish_out();
    checks++; if (res !== 3'b111 || lat !== PIT+1) begin
      failures++; $display("FAIL coll_result: got %b lat %0d want 111 lat %0d", res, lat, PIT+1);
    end
  endtask

  task automatic test_backpressure();
    logic b1, b2, b3;
    int lat;
    start_eval(4'b1110, b1, b2, b3);
    wait_out(lat);
    checks++; if (out_data !== 3'b110) begin failures++; $display("FAIL bp_first: got %b want 110", out_data); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_data !== 3'b110 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold_%0d: got vld %b data %b in_ready %b want 1 110 0", c, out_valid, out_data, in_ready);
      end
    end
    finish_out();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_eval();
    logic b1, b2, b3;
    logic [2:0] res;
    int lat;
    start_eval(4'b0000, b1, b2, b3);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_data !== 3'b000) begin
      failures++;
      $display("FAIL mid_rst: got vld %b busy %b in_ready %b data %b want 0 0 1 000", out_valid, busy, in_ready, out_data);
    end
    #1;
    rst_n = 1'b1;
    model_clear();
    @(posedge clk); #1;
    run_eval(4'b0000, res, lat);
    checks++; if (res !== 3'b000) begin failures++; $display("FAIL cleared_0000: got %b want 000", res); end
    run_eval(4'b1110, res, lat);
    checks++; if (res !== 3'b000) begin failures++; $display("FAIL cleared_1110: got %b want 000", res); end
    run_eval(4'b0001, res, lat);
    checks++; if (res !== 3'b000) begin failures++; $display("FAIL cleared_0001: got %b want 000", res); end
  endtask

  task automatic test_back_to_back();
    int hs_idx[$];
    logic hs;
    int lat;
    in_valid = 1'b1; in_data = 4'b0010; out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      hs = in_ready;
      @(posedge clk);
      if (hs) hs_idx.push_back(i);
      #1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (hs_idx.size() !== 3) begin failures++; $display("FAIL b2b_count: got %0d want 3", hs_idx.size()); end
    checks++; if (hs_idx.size() < 2 || (hs_idx[1] - hs_idx[0]) !== PIT+2) begin
      failures++;
      $display("FAIL b2b_interval: got %0d want %0d", (hs_idx.size() < 2) ? -1 : hs_idx[1] - hs_idx[0], PIT+2);
    end
    wait_out(lat);
    if (lat > 0) finish_out();
  endtask

  initial begin
    test_reset();
    test_lpp_check();
    test_empty_table();
    test_single_product();
    test_full_table();
    test_collision();
    test_backpressure();
    test_reset_mid_eval();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
